// File: rtl/mux_share_arbiter_if.sv
// Bundle of request/grant signals between the four requesters and the
// shared-mux arbiter. The requesters sit on the master side; the arbiter
// sits on the slave side.
interface mux_share_arbiter_if;
  logic [3:0] i_req;
  logic [3:0] i_last;
  logic [3:0] o_grant;
  logic [1:0] o_sel;
  logic       o_valid;
  logic [7:0] o_owner_cnt;

  modport master (
    output i_req,
    output i_last,
    input  o_grant,
    input  o_sel,
    input  o_valid,
    input  o_owner_cnt
  );

  modport slave (
    input  i_req,
    input  i_last,
    output o_grant,
    output o_sel,
    output o_valid,
    output o_owner_cnt
  );
endinterface

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter for the shared 32-bit 4:1 data mux.
// A tenure ends on the owner's i_last, on the owner dropping its request,
// or on reaching HOLD_MAX granted cycles. Every release goes through one
// IDLE cycle, where re-arbitration starts after the previous winner so the
// releasing requester has the lowest priority.
// All outputs come straight from flops; they are loaded from the next-state
// values so they line up exactly with the state registers.
module mux_share_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input logic               clk,
  input logic               reset_n,
  mux_share_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);
  localparam logic [7:0] CNT_SAT    = 8'd255;

  // Round-robin pick: first set request searching ptr+1, ptr+2, ptr+3, ptr.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  logic [0:0] state_r;
  logic [0:0] state_nx_s;
  logic [1:0] ptr_r;
  logic [1:0] ptr_nx_s;
  logic [1:0] owner_r;
  logic [1:0] owner_nx_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nx_s;
  logic [1:0] pick_s;
  logic       release_s;

  logic [3:0] grant_r;
  logic [1:0] sel_r;
  logic       valid_r;
  logic [7:0] owner_cnt_r;

  // Next-state logic: arbitration in IDLE, release/count tracking in OWN.
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    owner_nx_s = owner_r;
    cnt_nx_s   = cnt_r;
    pick_s     = rr_pick(bus.i_req, ptr_r);
    release_s  = bus.i_last[owner_r] | ~bus.i_req[owner_r] |
                 (cnt_r == HOLD_MAX_C);
    case (state_r)
      IDLE: begin
        if (bus.i_req != 4'b0000) begin
          owner_nx_s = pick_s;
          ptr_nx_s   = pick_s;
          cnt_nx_s   = 8'd1;
          state_nx_s = OWN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      OWN: begin
        if (release_s) begin
          state_nx_s = IDLE;
          cnt_nx_s   = 8'd0;
        end else if (cnt_r != CNT_SAT) begin
          cnt_nx_s   = cnt_r + 8'd1;
        end else begin
          cnt_nx_s   = cnt_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 8'd0;
      end
    endcase
  end

  // Arbitration state; reset leaves ptr at 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      ptr_r   <= 2'd3;
      owner_r <= 2'd0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nx_s;
      ptr_r   <= ptr_nx_s;
      owner_r <= owner_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Output flops decoded from the next state, so they track state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_r     <= 4'b0000;
      sel_r       <= 2'd0;
      valid_r     <= 1'b0;
      owner_cnt_r <= 8'd0;
    end else begin
      valid_r     <= (state_nx_s == OWN);
      grant_r     <= (state_nx_s == OWN) ? (4'b0001 << owner_nx_s) : 4'b0000;
      sel_r       <= owner_nx_s;
      owner_cnt_r <= cnt_nx_s;
    end
  end

  assign bus.o_grant     = grant_r;
  assign bus.o_sel       = sel_r;
  assign bus.o_valid     = valid_r;
  assign bus.o_owner_cnt = owner_cnt_r;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Scoreboard bench for mux_share_arbiter. Two instances: HOLD_MAX = 4 and
// HOLD_MAX = 1. Expected output tuples are queued when stimulus is driven
// and compared after the following rising edge.
module tb_mux_share_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic [7:0] cnt;
  } obs_t;

  logic clk;
  logic reset_n;

  mux_share_arbiter_if bus4 ();
  mux_share_arbiter_if bus1 ();

  mux_share_arbiter #(.HOLD_MAX(4)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  mux_share_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  obs_t sb[$];
  int   n_checks;
  int   n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] g, input logic [1:0] s,
                              input logic v, input logic [7:0] c);
    obs_t o;
    o.grant = g;
    o.sel   = s;
    o.valid = v;
    o.cnt   = c;
    return o;
  endfunction

  function automatic obs_t obs4();
    return mk(bus4.o_grant, bus4.o_sel, bus4.o_valid, bus4.o_owner_cnt);
  endfunction

  function automatic obs_t obs1();
    return mk(bus1.o_grant, bus1.o_sel, bus1.o_valid, bus1.o_owner_cnt);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    bus4.i_req  = 4'b0000;
    bus4.i_last = 4'b0000;
    bus1.i_req  = 4'b0000;
    bus1.i_last = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t want;
    logic [3:0] req_t [12];
    obs_t exp_t [12];
    #3;
    for (int d = 0; d < 2; d++) begin
      sb.push_back(mk(4'b0000, 2'd0, 1'b0, 8'd0));
      got  = (d == 0) ? obs4() : obs1();
      want = sb.pop_front();
      n_checks++;
      if (got !== want)
        $display("FAIL reset_hold dut%0d: got %b/%0d/%b/%0d expected %b/%0d/%b/%0d",
                 d, got.grant, got.sel, got.valid, got.cnt,
                 want.grant, want.sel, want.valid, want.cnt);
      else
        n_pass++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_t[i] = 4'b0000;
      exp_t[i] = mk(4'b0000, 2'd0, 1'b0, 8'd0);
    end
    req_t[10] = 4'b1111; exp_t[10] = mk(4'b0001, 2'd0, 1'b1, 8'd1);
    req_t[11] = 4'b0000; exp_t[11] = mk(4'b0000, 2'd0, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++) begin
      bus4.i_req  = req_t[i];
      bus4.i_last = 4'b0000;
      sb.push_back(exp_t[i]);
      @(posedge clk); #1;
      got  = obs4();
      want = sb.pop_front();
      n_checks++;
      if (got !== want)
        $display("FAIL reset_defaults step %0d: got %b/%0d/%b/%0d expected %b/%0d/%b/%0d",
                 i, got.grant, got.sel, got.valid, got.cnt,
                 want.grant, want.sel, want.valid, want.cnt);
      else
        n_pass++;
    end
  endtask

  task automatic test_round_robin();
    obs_t got;
    obs_t want;
    obs_t exp_t [22];
    int n;
    n = 0;
    for (int t = 0; t < 4; t++) begin
      for (int c = 1; c <= 4; c++) begin
        exp_t[n] = mk(4'b0001 << t, 2'(t), 1'b1, 8'(c));
        n++;
      end
      exp_t[n] = mk(4'b0000, 2'(t), 1'b0, 8'd0);
      n++;
    end
    exp_t[20] = mk(4'b0001, 2'd0, 1'b1, 8'd1);
    exp_t[21] = mk(4'b0000, 2'd0, 1'b0, 8'd0);
    do_reset();
    for (int i = 0; i < 22; i++) begin
      bus4.i_req  = (i < 21) ? 4'b1111 : 4'b0000;
      bus4.i_last = 4'b0000;
      sb.push_back(exp_t[i]);
      @(posedge clk); #1;
      got  = obs4();
      want = sb.pop_front();
      n_checks++;
      if (got !== want)
        $display("FAIL round_robin step %0d: got %b/%0d/%b/%0d expected %b/%0d/%b/%0d",
                 i, got.grant, got.sel, got.valid, got.cnt,
                 want.grant, want.sel, want.valid, want.cnt);
      else
        n_pass++;
    end
  endtask

  task automatic test_early_release();
    obs_t got;
    obs_t want;
    logic [3:0] req_t [6]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] last_t [6] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    obs_t exp_t [6];
    exp_t[0] = mk(4'b0100, 2'd2, 1'b1, 8'd1);
    exp_t[1] = mk(4'b0100, 2'd2, 1'b1, 8'd2);
    exp_t[2] = mk(4'b0000, 2'd2, 1'b0, 8'd0);
    exp_t[3] = mk(4'b0100, 2'd2, 1'b1, 8'd1);
    exp_t[4] = mk(4'b0000, 2'd2, 1'b0, 8'd0);
    exp_t[5] = mk(4'b0000, 2'd2, 1'b0, 8'd0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus4.i_req  = req_t[i];
      bus4.i_last = last_t[i];
      sb.push_back(exp_t[i]);
      @(posedge clk); #1;
      got  = obs4();
      want = sb.pop_front();
      n_checks++;
      if (got !== want)
        $display("FAIL early_release step %0d: got %b/%0d/%b/%0d expected %b/%0d/%b/%0d",
                 i, got.grant, got.sel, got.valid, got.cnt,
                 want.grant, want.sel, want.valid, want.cnt);
      else
        n_pass++;
    end
  endtask

  task automatic test_ignored_signals();
    obs_t got;
    obs_t want;
    logic [3:0] req_t [7]  = '{4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0000};
    logic [3:0] last_t [7] = '{4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    obs_t exp_t [7];
    exp_t[0] = mk(4'b0010, 2'd1, 1'b1, 8'd1);
    exp_t[1] = mk(4'b0010, 2'd1, 1'b1, 8'd2);
    exp_t[2] = mk(4'b0010, 2'd1, 1'b1, 8'd3);
    exp_t[3] = mk(4'b0010, 2'd1, 1'b1, 8'd4);
    exp_t[4] = mk(4'b0000, 2'd1, 1'b0, 8'd0);
    exp_t[5] = mk(4'b0001, 2'd0, 1'b1, 8'd1);
    exp_t[6] = mk(4'b0000, 2'd0, 1'b0, 8'd0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus4.i_req  = req_t[i];
      bus4.i_last = last_t[i];
      sb.push_back(exp_t[i]);
      @(posedge clk); #1;
      got  = obs4();
      want = sb.pop_front();
      n_checks++;
      if (got !== want)
        $display("FAIL ignored_signals step %0d: got %b/%0d/%b/%0d expected %b/%0d/%b/%0d",
                 i, got.grant, got.sel, got.valid, got.cnt,
                 want.grant, want.sel, want.valid, want.cnt);
      else
        n_pass++;
    end
  endtask

  task automatic test_async_reset();
    obs_t got;
    obs_t want;
    logic [3:0] req_t [5] = '{4'b1000, 4'b1000, 4'b0000, 4'b1010, 4'b0000};
    obs_t exp_t [5];
    exp_t[0] = mk(4'b1000, 2'd3, 1'b1, 8'd1);
    exp_t[1] = mk(4'b1000, 2'd3, 1'b1, 8'd2);
    exp_t[2] = mk(4'b0000, 2'd0, 1'b0, 8'd0);
    exp_t[3] = mk(4'b0010, 2'd1, 1'b1, 8'd1);
    exp_t[4] = mk(4'b0000, 2'd1, 1'b0, 8'd0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus4.i_req  = req_t[i];
      bus4.i_last = 4'b0000;
      sb.push_back(exp_t[i]);
      if (i == 2) begin
        // Mid-cycle reset: outputs must clear before any further edge.
        #2;
        reset_n = 1'b0;
        #1;
      end else begin
        @(posedge clk); #1;
      end
      got  = obs4();
      want = sb.pop_front();
      n_checks++;
      if (got !== want)
        $display("FAIL async_reset step %0d: got %b/%0d/%b/%0d expected %b/%0d/%b/%0d",
                 i, got.grant, got.sel, got.valid, got.cnt,
                 want.grant, want.sel, want.valid, want.cnt);
      else
        n_pass++;
      if (i == 2) begin
        bus4.i_req = 4'b1010;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
  endtask

  task automatic test_single_cycle();
    obs_t got;
    obs_t want;
    obs_t exp_t [9];
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        exp_t[i] = ((i / 2) % 2 == 0) ? mk(4'b0001, 2'd0, 1'b1, 8'd1)
                                      : mk(4'b0100, 2'd2, 1'b1, 8'd1);
      else
        exp_t[i] = ((i / 2) % 2 == 0) ? mk(4'b0000, 2'd0, 1'b0, 8'd0)
                                      : mk(4'b0000, 2'd2, 1'b0, 8'd0);
    end
    exp_t[8] = mk(4'b0000, 2'd2, 1'b0, 8'd0);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus1.i_req  = (i < 8) ? 4'b0101 : 4'b0000;
      bus1.i_last = 4'b0000;
      sb.push_back(exp_t[i]);
      @(posedge clk); #1;
      got  = obs1();
      want = sb.pop_front();
      n_checks++;
      if (got !== want)
        $display("FAIL single_cycle step %0d: got %b/%0d/%b/%0d expected %b/%0d/%b/%0d",
                 i, got.grant, got.sel, got.valid, got.cnt,
                 want.grant, want.sel, want.valid, want.cnt);
      else
        n_pass++;
    end
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset_n     = 1'b0;
    bus4.i_req  = 4'b0000;
    bus4.i_last = 4'b0000;
    bus1.i_req  = 4'b0000;
    bus1.i_last = 4'b0000;
    test_reset();
    test_round_robin();
    test_early_release();
    test_ignored_signals();
    test_async_reset();
    test_single_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
